// File: rtl/regfile_pkg.sv
// Shared definitions for the parameterised register file: default widths and
// the clear/ready state encoding.
package regfile_pkg;
  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 3;
  localparam int DEF_NUM_RD     = 2;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;
endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: array mux, same-cycle write forwarding and the
// zero-forcing rules (clear in progress, hardwired entry 0).
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  state_t                                      state,
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]  mem,
  input  logic [ADDR_WIDTH-1:0]                       rd_addr,
  input  logic                                        wr_acc,
  input  logic [ADDR_WIDTH-1:0]                       waddr,
  input  logic [DATA_WIDTH-1:0]                       wdata,
  input  logic [DATA_WIDTH/8-1:0]                     wstrb,
  output logic [DATA_WIDTH-1:0]                       rd_data
);

  always_comb begin
    rd_data = mem[rd_addr];
    if (BYPASS != 0 && wr_acc && rd_addr == waddr) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wstrb[i]) rd_data[8*i +: 8] = wdata[8*i +: 8];
      end
    end
    // Clear-in-progress and the hardwired zero entry override any forwarding.
    if (state == CLEAR || (ZERO_REG != 0 && rd_addr == '0)) rd_data = '0;
  end

endmodule

// File: rtl/regfile_param.sv
// Parameterised register file with byte-strobed writes, NUM_RD read ports and a
// sequenced soft clear that walks every entry before accepting writes.
//   state | meaning
//   CLEAR | zeroing entry clr_idx each edge; reads return 0, writes dropped
//   READY | storage valid; strobed writes accepted
module regfile_param
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = DEF_NUM_RD,
  parameter int ZERO_REG   = 0,
  parameter int BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  input  logic                         wena,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH/8-1:0]      wstrb,
  input  logic                         clr,
  output logic                         ready,
  output logic                         wr_drop
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam int NB    = DATA_WIDTH/8;

  state_t                               state;
  logic [ADDR_WIDTH-1:0]                clr_idx;
  logic [DEPTH-1:0][DATA_WIDTH-1:0]     mem;
  logic                                 hit_zero;
  logic                                 strb_any;
  logic                                 wr_acc;
  logic                                 wr_bad;

  assign hit_zero = (ZERO_REG != 0) && (waddr == '0);
  assign strb_any = |wstrb;
  assign wr_acc   = (state == READY) && wena && !clr && strb_any && !hit_zero;
  assign wr_bad   = wena && strb_any && ((state == CLEAR) || clr || hit_zero);
  assign ready    = (state == READY);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
      wr_drop <= 1'b0;
    end else begin
      wr_drop <= wr_bad;
      if (clr) begin
        state   <= CLEAR;
        clr_idx <= '0;
      end else if (state == CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == ADDR_WIDTH'(DEPTH-1)) state <= READY;
      end
    end
  end

  // Storage is deliberately not reset; the clear walk is the only way to zero it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rd_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_rd (
      .state   (state),
      .mem     (mem),
      .rd_addr (rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH]),
      .wr_acc  (wr_acc),
      .waddr   (waddr),
      .wdata   (wdata),
      .wstrb   (wstrb),
      .rd_data (rd_data[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (zero-reg+bypass, plain) driven in parallel
// and checked every cycle against a behavioural model, plus literal spot checks.
module tb_regfile_param;
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [5:0]   rd_addr = '0;
  logic         wena = 1'b0;
  logic [2:0]   waddr = '0;
  logic [63:0]  wdata = '0;
  logic [7:0]   wstrb = '0;
  logic         clr = 1'b0;
  logic [127:0] rd_a, rd_b;
  logic         rdy_a, rdy_b, drp_a, drp_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  regfile_param #(.ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_a), .wena(wena),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .clr(clr), .ready(rdy_a), .wr_drop(drp_a));

  regfile_param #(.ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_b), .wena(wena),
    .waddr(waddr), .wdata(wdata), .wstrb(wstrb), .clr(clr), .ready(rdy_b), .wr_drop(drp_b));

  // Model: instance 0 = zero-reg + bypass, instance 1 = neither.
  logic [63:0] mmem [2][8];
  bit          mrdy [2];
  int          ccnt [2];
  bit          mdrop[2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int e = 0; e < 8; e++) mmem[k][e] = '0;
      mrdy[k] = 0; ccnt[k] = 0; mdrop[k] = 0;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] s);
    logic [63:0] r = old;
    for (int i = 0; i < 8; i++) if (s[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic bit accepts(input int k);
    return reset && mrdy[k] && wena && !clr && (wstrb != 0) && !(k == 0 && waddr == 0);
  endfunction

  function automatic logic [63:0] exp_rd(input int k, input logic [2:0] a);
    if (!reset || !mrdy[k]) return '0;
    if (k == 0 && a == 0) return '0;
    if (k == 0 && accepts(k) && a == waddr) return merge(mmem[k][a], wdata, wstrb);
    return mmem[k][a];
  endfunction

  // Compare at the falling edge, advance the model at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int k = 0; k < 2; k++) begin mrdy[k] = 0; ccnt[k] = 0; mdrop[k] = 0; end
      end
      chk("ready_a", {127'b0, rdy_a}, {127'b0, mrdy[0]});
      chk("ready_b", {127'b0, rdy_b}, {127'b0, mrdy[1]});
      chk("drop_a", {127'b0, drp_a}, {127'b0, mdrop[0]});
      chk("drop_b", {127'b0, drp_b}, {127'b0, mdrop[1]});
      chk("rd_a", rd_a, {exp_rd(0, rd_addr[5:3]), exp_rd(0, rd_addr[2:0])});
      chk("rd_b", rd_b, {exp_rd(1, rd_addr[5:3]), exp_rd(1, rd_addr[2:0])});
      @(posedge clk);
      if (reset) begin
        for (int k = 0; k < 2; k++) begin
          bit acc;
          acc = accepts(k);
          mdrop[k] = wena && (wstrb != 0) && (!mrdy[k] || clr || (k == 0 && waddr == 0));
          if (acc) mmem[k][waddr] = merge(mmem[k][waddr], wdata, wstrb);
          if (clr) begin
            mrdy[k] = 0; ccnt[k] = 0;
          end else if (!mrdy[k]) begin
            ccnt[k]++;
            if (ccnt[k] == 8) begin
              mrdy[k] = 1;
              for (int e = 0; e < 8; e++) mmem[k][e] = '0;
            end
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic count_to_ready(input string name);
    for (int e = 1; e <= 8; e++) begin
      cyc();
      #1 chk(name, {126'b0, rdy_a, rdy_b}, (e == 8) ? 128'd3 : 128'd0);
    end
  endtask

  initial begin
    cyc(); cyc();
    #1 chk("rst_ready", {126'b0, rdy_a, rdy_b}, 128'd0);
    chk("rst_rd", rd_b, 128'd0);
    reset = 1'b1;
    count_to_ready("init_ready");
    rd_addr = {3'd7, 3'd4};
    #1 chk("init_zero", rd_b, 128'd0);

    // Partial-strobe overwrite
    cyc();
    wena = 1; waddr = 5; wdata = 64'h1122334455667788; wstrb = 8'hFF;
    cyc();
    wdata = 64'hAAAAAAAAAAAAAAAA; wstrb = 8'h0F;
    cyc();
    wena = 0; rd_addr = {3'd0, 3'd5};
    #1 chk("strb_a", {64'b0, rd_a[63:0]}, {64'b0, 64'h11223344AAAAAAAA});
    chk("strb_b", {64'b0, rd_b[63:0]}, {64'b0, 64'h11223344AAAAAAAA});

    // Same-cycle forwarding
    cyc();
    wena = 1; waddr = 3; wdata = 64'hDEAD; wstrb = 8'hFF; rd_addr = {3'd3, 3'd3};
    #1 chk("bypass_a", rd_a, {64'hDEAD, 64'hDEAD});
    chk("nobypass_b", rd_b, 128'd0);
    cyc();
    wena = 0;
    #1 chk("after_b", rd_b, {64'hDEAD, 64'hDEAD});

    // Write colliding with clear request
    wena = 1; waddr = 2; wdata = '1; wstrb = 8'hFF; clr = 1;
    cyc();
    wena = 0; clr = 0; rd_addr = {3'd2, 3'd2};
    #1 chk("clr_drop", {126'b0, drp_a, drp_b}, 128'd3);
    chk("clr_ready", {126'b0, rdy_a, rdy_b}, 128'd0);
    cyc();
    #1 chk("drop_once", {126'b0, drp_a, drp_b}, 128'd0);
    for (int e = 2; e <= 8; e++) begin
      cyc();
      #1 chk("clr_ready_cnt", {126'b0, rdy_a, rdy_b}, (e == 8) ? 128'd3 : 128'd0);
    end
    chk("clr_entry2", rd_b, 128'd0);

    // Hardwired entry 0
    cyc();
    wena = 1; waddr = 0; wdata = 64'hFF; wstrb = 8'hFF; rd_addr = 6'd0;
    #1 chk("zr_bypass", rd_a, 128'd0);
    cyc();
    wena = 0;
    #1 chk("zr_drop", {126'b0, drp_a, drp_b}, 128'd2);
    chk("zr_read", {rd_a[63:0], rd_b[63:0]}, {64'd0, 64'hFF});

    // Reset in the middle of a clear walk
    clr = 1;
    cyc();
    clr = 0;
    repeat (4) cyc();
    reset = 0;
    #1 chk("midrst_ready", {126'b0, rdy_a, rdy_b}, 128'd0);
    chk("midrst_rd", rd_b, 128'd0);
    cyc();
    reset = 1;
    count_to_ready("midrst_cnt");

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      reset   = ($urandom_range(0, 199) != 0);
      clr     = ($urandom_range(0, 39) == 0);
      wena    = $urandom_range(0, 1);
      waddr   = 3'($urandom_range(0, 7));
      wdata   = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: wstrb = 8'h00;
        1: wstrb = 8'hFF;
        default: wstrb = 8'($urandom);
      endcase
      rd_addr = ($urandom_range(0, 3) == 0) ? {waddr, waddr} : 6'($urandom);
    end
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 Parameter DATA_WIDTH, default 64, word width; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_WIDTH, default 3, address width; DEPTH = 2**ADDR_WIDTH entries.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports.
REQ-004 Parameter ZERO_REG, default 0; when 1, entry 0 is hardwired to zero.
REQ-005 Parameter BYPASS, default 1; when 1, a same-cycle write is forwarded to matching read ports.
REQ-006 clk  in  1  sole clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 rd_addr  in  NUM_RD*ADDR_WIDTH  packed read addresses; port p uses slice p.
REQ-009 rd_data  out  NUM_RD*DATA_WIDTH  packed combinational read data; port p uses slice p.
REQ-010 wena  in  1  write request.
REQ-011 waddr  in  ADDR_WIDTH  write address.
REQ-012 wdata  in  DATA_WIDTH  write data.
REQ-013 wstrb  in  DATA_WIDTH/8  byte write enables; bit i covers wdata[8i+7:8i].
REQ-014 clr  in  1  single-cycle soft-clear request.
REQ-015 ready  out  1  high when the clear sequence is complete and writes are accepted.
REQ-016 wr_drop  out  1  registered one-cycle pulse flagging a discarded write.

Function
REQ-017 The block SHALL have two states: CLEAR and READY; ready = (state == READY).
REQ-018 In CLEAR, a counter clr_idx SHALL zero entry clr_idx on each rising edge and then increment; on the edge that zeroes entry DEPTH-1, state SHALL become READY, so ready rises exactly DEPTH edges after CLEAR is entered.
REQ-019 In READY, clr=1 SHALL move the block to CLEAR with clr_idx=0 on the next edge.
REQ-020 In CLEAR, clr=1 SHALL restart the sequence with clr_idx=0 on the next edge.
REQ-021 In READY, with wena=1 and clr=0, each byte i with wstrb[i]=1 SHALL be written to entry waddr on the edge; bytes with wstrb[i]=0 SHALL keep their value.
REQ-022 A write with wstrb all zero SHALL change no state and SHALL NOT be flagged as dropped.
REQ-023 A write with wena=1 SHALL be dropped, and wr_drop SHALL pulse high for one cycle after the edge, when any of these hold: state is CLEAR, clr=1, or ZERO_REG=1 with waddr=0.
REQ-024 rd_data port p SHALL show entry rd_addr[p] combinationally, with zero read latency.
REQ-025 While state is CLEAR, every rd_data port SHALL read 0.
REQ-026 With ZERO_REG=1, a read of address 0 SHALL return 0 in every state.
REQ-027 With BYPASS=1, if a write is accepted this cycle and rd_addr[p]==waddr, port p SHALL return wdata bytes where wstrb[i]=1 and stored bytes elsewhere.
REQ-028 With BYPASS=0, port p SHALL return the pre-edge stored value.
REQ-029 Multiple read ports addressing the same entry SHALL all return identical data.

Reset
REQ-030 While reset=0: state=CLEAR, clr_idx=0, wr_drop=0, ready=0, and rd_data reads 0.
REQ-031 The storage array SHALL NOT be asynchronously reset; it is cleared only by the CLEAR sequence, which starts on the first edge after reset rises.
REQ-032 Reset asserted mid-CLEAR or mid-write SHALL abort the operation; the full clear sequence SHALL rerun after release.

Structure
REQ-033 A package regfile_pkg SHALL hold the state enumeration and the default widths (64, 3, 2) used across cores.
REQ-034 One sub-module, regfile_rd_port, SHALL implement a single read mux, including zero-register and bypass merge; it SHALL be instantiated NUM_RD times by a generate loop.

Verification (DATA_WIDTH=64, ADDR_WIDTH=3, NUM_RD=2)
REQ-035 Release reset, idle -> ready=0 for edges 1-7, ready=1 after edge 8; all entries read 0.
REQ-036 READY, write addr 5 = 0x1122334455667788 with wstrb=0xFF, then addr 5 = 0xAAAA... with wstrb=0x0F -> port 0 reads 0x11223344AAAAAAAA.
REQ-037 BYPASS=1, same-cycle write addr 3 = 0xDEAD with wstrb=0xFF while rd_addr[1]=3 -> rd_data[1]=0xDEAD in that cycle.
REQ-038 Write addr 2 issued on the same edge as clr=1 -> write dropped, wr_drop pulses once, ready falls, and it rises 8 edges later with entry 2 = 0.
REQ-039 ZERO_REG=1, write addr 0 = 0xFF -> wr_drop=1, addr 0 reads 0.
REQ-040 Reset pulsed at clr_idx=4 -> ready=0 and reads 0; after release, ready rises after exactly 8 edges.
